pipe_ctl: RTL and testbench

Pipeline sequencer for the 16-bit, 9-bit-PC processor.
- Owns the program counter and drives instruction fetch.
- Applies jump/branch redirects with a fixed flush window and handles HLT/NOP halt control.
- Arbitrates the single-port 512x16 unified memory between instruction fetch, loads (op 1001) and stores (op 1010) from the execute stage.

---
 rtl/pipe_ctl_pkg.sv | 35 +++
 rtl/pipe_ctl_mem_port_arb.sv | 70 +++++++
 rtl/pipe_ctl.sv | 192 +++++++++++++++++++
 tb/tb_pipe_ctl.sv | 305 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pipe_ctl_pkg.sv
// Purpose : shared types and constants for the pipeline sequencer.
// Latency : n/a (types and constants only).
// Backpress: n/a.
//
// Contents: opcode constants, sequencer state enum, memory-port grant enum,
// default address/data widths.

package pipe_pkg;

    localparam int ADDR_W_DEF = 9;
    localparam int DATA_W_DEF = 16;

    localparam logic [3:0] OP_NOP = 4'b0000;
    localparam logic [3:0] OP_LD  = 4'b1001;
    localparam logic [3:0] OP_ST  = 4'b1010;
    localparam logic [3:0] OP_BEQ = 4'b1100;
    localparam logic [3:0] OP_BGT = 4'b1101;
    localparam logic [3:0] OP_JMP = 4'b1110;
    localparam logic [3:0] OP_HLT = 4'b1111;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        FLUSH = 2'd2,
        HALT  = 2'd3
    } ctl_state_t;

    typedef enum logic [1:0] {
        G_NONE  = 2'd0,
        G_FETCH = 2'd1,
        G_LD    = 2'd2,
        G_ST    = 2'd3
    } grant_t;

endpackage

// File: rtl/pipe_ctl_mem_port_arb.sv
// Purpose : fixed-priority arbiter (store > load > fetch) for the single-port memory.
// Latency : grant is combinational; return tag is registered, so read data steers one cycle later.
// Backpress: losers are simply not granted this cycle; requesters hold their request.
//
// Ports:
//   ck, rst                      clock, synchronous active-high reset
//   st_req/st_addr/st_data       store request from execute
//   ld_req/ld_addr               load request from execute
//   fetch_req/fetch_addr         instruction fetch request at the fetch pointer
//   fetch_keep                   a granted fetch is tagged for return (0 = issue but discard)
//   grant                        this cycle's winner
//   ret_tag                      winner of the previous cycle, i.e. owner of mem_rdata now
//   mem_addr/mem_we/mem_wdata    memory port drive

module mem_port_arb
    import pipe_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int DATA_W = DATA_W_DEF
) (
    input  logic              ck,
    input  logic              rst,
    input  logic              st_req,
    input  logic [ADDR_W-1:0] st_addr,
    input  logic [DATA_W-1:0] st_data,
    input  logic              ld_req,
    input  logic [ADDR_W-1:0] ld_addr,
    input  logic              fetch_req,
    input  logic [ADDR_W-1:0] fetch_addr,
    input  logic              fetch_keep,
    output grant_t            grant,
    output grant_t            ret_tag,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_we,
    output logic [DATA_W-1:0] mem_wdata
);

    always_comb begin
        grant     = G_NONE;
        mem_addr  = '0;
        mem_we    = 1'b0;
        mem_wdata = '0;
        if (st_req) begin
            grant     = G_ST;
            mem_addr  = st_addr;
            mem_we    = 1'b1;
            mem_wdata = st_data;
        end else if (ld_req) begin
            grant    = G_LD;
            mem_addr = ld_addr;
        end else if (fetch_req) begin
            grant    = G_FETCH;
            mem_addr = fetch_addr;
        end
    end

    // Stores return nothing, but tagging them is harmless: only G_FETCH and
    // G_LD steer read data. A fetch that is issued without being kept (flush
    // refetch, killed by redirect/halt) leaves no tag, so its data is dropped.
    always_ff @(posedge ck) begin
        if (rst) begin
            ret_tag <= G_NONE;
        end else if (grant == G_FETCH && !fetch_keep) begin
            ret_tag <= G_NONE;
        end else begin
            ret_tag <= grant;
        end
    end

endmodule

// File: rtl/pipe_ctl.sv
// Purpose : pipeline sequencer - owns the PC, fetches, applies redirects/halt, shares the memory port.
// Latency : fetch and load data return 1 cycle after grant; redirect gives FLUSH_CYCLES dead cycles.
// Backpress: fetch yields the port to store/load (fetch_stall=1) and retries the same address.
//
// Ports:
//   ck, rst                 clock, synchronous active-high reset
//   start                   leave IDLE/HALT and fetch from the held pointer
//   ex_*                    execute-stage controls: op, redirect, store
//   ld_req/ld_addr          load request
//   mem_*                   single-port 512x16 memory interface (read latency 1)
//   pc/instr/instr_valid    fetched instruction stream
//   ld_data/ld_valid        load return
//   fetch_stall, halted     status
// Optional feature macro PIPE_CTL_PERF_EN adds perf_stall_cnt / perf_flush_cnt.

module pipe_ctl
    import pipe_pkg::*;
#(
    parameter int                ADDR_W       = ADDR_W_DEF,
    parameter int                DATA_W       = DATA_W_DEF,
    parameter logic [ADDR_W-1:0] RESET_PC     = '0,
    parameter int                FLUSH_CYCLES = 3
) (
    input  logic              ck,
    input  logic              rst,
    input  logic              start,
    input  logic              ex_valid,
    input  logic [3:0]        ex_op,
    input  logic              ex_is_jump,
    input  logic [ADDR_W-1:0] ex_next_pc,
    input  logic              ex_is_write,
    input  logic [ADDR_W-1:0] ex_write_addr,
    input  logic [DATA_W-1:0] ex_data,
    input  logic              ld_req,
    input  logic [ADDR_W-1:0] ld_addr,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_we,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic [ADDR_W-1:0] pc,
    output logic [DATA_W-1:0] instr,
    output logic              instr_valid,
    output logic [DATA_W-1:0] ld_data,
    output logic              ld_valid,
    output logic              fetch_stall,
    output logic              halted
`ifdef PIPE_CTL_PERF_EN
    ,
    output logic [15:0]       perf_stall_cnt,
    output logic [15:0]       perf_flush_cnt
`endif
);

    localparam logic [2:0] FLUSH_LD = 3'(FLUSH_CYCLES);

    ctl_state_t        state_q, state_d;
    logic [2:0]        cnt_q, cnt_d;
    logic [ADDR_W-1:0] fptr_q, fptr_d;
    logic [ADDR_W-1:0] pc_q;

    logic   active;
    logic   redirect;
    logic   halt_cmd;
    logic   fetch_keep;
    logic   fetch_adv;
    grant_t grant;
    grant_t ret_tag;

    // Execute-stage controls only act while the pipeline is running.
    assign active   = (state_q == RUN) || (state_q == FLUSH);
    assign redirect = active && ex_valid && ex_is_jump;
    assign halt_cmd = active && ex_valid && (ex_op == OP_HLT);

    // During FLUSH the port keeps fetching the redirect target, but only the
    // fetch in the last flush cycle is kept and advances the pointer; that
    // makes the first valid instruction after the window the target itself.
    // A fetch issued in a redirect or halt cycle is the in-flight fetch that
    // gets discarded; leaving the pointer untouched is the halt rewind.
    assign fetch_keep = active && !redirect && !halt_cmd &&
                        ((state_q == RUN) || (cnt_q == 3'd1));
    assign fetch_adv  = (grant == G_FETCH) && fetch_keep;

    mem_port_arb #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W)
    ) u_arb (
        .ck         (ck),
        .rst        (rst),
        .st_req     (ex_valid && ex_is_write),
        .st_addr    (ex_write_addr),
        .st_data    (ex_data),
        .ld_req     (ld_req),
        .ld_addr    (ld_addr),
        .fetch_req  (active),
        .fetch_addr (fptr_q),
        .fetch_keep (fetch_keep),
        .grant      (grant),
        .ret_tag    (ret_tag),
        .mem_addr   (mem_addr),
        .mem_we     (mem_we),
        .mem_wdata  (mem_wdata)
    );

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            IDLE, HALT: begin
                if (start) begin
                    state_d = RUN;
                end
            end
            RUN: begin
                if (halt_cmd) begin
                    state_d = HALT;
                end else if (redirect) begin
                    state_d = FLUSH;
                    cnt_d   = FLUSH_LD;
                end
            end
            FLUSH: begin
                if (halt_cmd) begin
                    state_d = HALT;
                    cnt_d   = '0;
                end else if (redirect) begin
                    cnt_d = FLUSH_LD;
                end else if (cnt_q == 3'd1) begin
                    state_d = RUN;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q - 3'd1;
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    // Halt wins over a simultaneous redirect for state, but the target still
    // lands in the pointer so a later start resumes there.
    always_comb begin
        fptr_d = fptr_q;
        if (redirect) begin
            fptr_d = ex_next_pc;
        end else if (fetch_adv) begin
            fptr_d = fptr_q + ADDR_W'(1);
        end
    end

    always_ff @(posedge ck) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            fptr_q  <= RESET_PC;
            pc_q    <= RESET_PC;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            fptr_q  <= fptr_d;
            if (fetch_adv) begin
                pc_q <= fptr_q;
            end
        end
    end

    assign pc          = pc_q;
    assign instr_valid = (ret_tag == G_FETCH) && (state_q == RUN);
    assign instr       = instr_valid ? mem_rdata : '0;
    assign ld_valid    = (ret_tag == G_LD);
    assign ld_data     = ld_valid ? mem_rdata : '0;
    assign fetch_stall = active && ((grant == G_ST) || (grant == G_LD));
    assign halted      = (state_q == HALT);

`ifdef PIPE_CTL_PERF_EN
    always_ff @(posedge ck) begin
        if (rst) begin
            perf_stall_cnt <= '0;
            perf_flush_cnt <= '0;
        end else begin
            if (fetch_stall && (perf_stall_cnt != 16'hFFFF)) begin
                perf_stall_cnt <= perf_stall_cnt + 16'd1;
            end
            if ((state_q == FLUSH) && (perf_flush_cnt != 16'hFFFF)) begin
                perf_flush_cnt <= perf_flush_cnt + 16'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_pipe_ctl.sv
// Purpose : self-checking bench for pipe_ctl with a behavioural 512x16 memory.
// Latency : memory read data appears one cycle after the address.
// Backpress: none; stimulus holds requests for the cycles it expects them to be granted.

module tb_pipe_ctl;

    typedef struct packed {
        logic [8:0]  pc;
        logic [15:0] ins;
    } exp_fetch_t;

    logic        ck;
    logic        rst;
    logic        start;
    logic        ex_valid;
    logic [3:0]  ex_op;
    logic        ex_is_jump;
    logic [8:0]  ex_next_pc;
    logic        ex_is_write;
    logic [8:0]  ex_write_addr;
    logic [15:0] ex_data;
    logic        ld_req;
    logic [8:0]  ld_addr;
    logic [8:0]  mem_addr;
    logic        mem_we;
    logic [15:0] mem_wdata;
    logic [15:0] mem_rdata;
    logic [8:0]  pc;
    logic [15:0] instr;
    logic        instr_valid;
    logic [15:0] ld_data;
    logic        ld_valid;
    logic        fetch_stall;
    logic        halted;
`ifdef PIPE_CTL_PERF_EN
    logic [15:0] perf_stall_cnt;
    logic [15:0] perf_flush_cnt;
`endif

    int n_cmp = 0;
    int n_err = 0;
    bit mon_en = 0;

    exp_fetch_t  exp_f[$];
    logic [15:0] exp_l[$];

    logic [15:0] mem [512];

    pipe_ctl dut (
        .ck            (ck),
        .rst           (rst),
        .start         (start),
        .ex_valid      (ex_valid),
        .ex_op         (ex_op),
        .ex_is_jump    (ex_is_jump),
        .ex_next_pc    (ex_next_pc),
        .ex_is_write   (ex_is_write),
        .ex_write_addr (ex_write_addr),
        .ex_data       (ex_data),
        .ld_req        (ld_req),
        .ld_addr       (ld_addr),
        .mem_addr      (mem_addr),
        .mem_we        (mem_we),
        .mem_wdata     (mem_wdata),
        .mem_rdata     (mem_rdata),
        .pc            (pc),
        .instr         (instr),
        .instr_valid   (instr_valid),
        .ld_data       (ld_data),
        .ld_valid      (ld_valid),
        .fetch_stall   (fetch_stall),
        .halted        (halted)
`ifdef PIPE_CTL_PERF_EN
        ,
        .perf_stall_cnt(perf_stall_cnt),
        .perf_flush_cnt(perf_flush_cnt)
`endif
    );

    initial ck = 1'b0;
    always #5 ck = ~ck;

    // Memory holds word i at address i, except the load test word at 0x40.
    initial begin
        for (int i = 0; i < 512; i++) mem[i] = 16'(i);
        mem[9'h040] = 16'hBEEF;
    end

    always @(posedge ck) begin
        if (mem_we) mem[mem_addr] <= mem_wdata;
        mem_rdata <= mem[mem_addr];
    end

    // Monitor: every presented fetch/load result is matched against the queues.
    always @(negedge ck) begin
        if (mon_en) begin
            if (instr_valid === 1'b1) begin
                n_cmp++;
                if (exp_f.size() == 0) begin
                    n_err++;
                    $display("FAIL fetch_unexpected got pc=%h instr=%h, none expected", pc, instr);
                end else begin
                    exp_fetch_t e;
                    e = exp_f.pop_front();
                    if (pc !== e.pc || instr !== e.ins) begin
                        n_err++;
                        $display("FAIL fetch got pc=%h instr=%h want pc=%h instr=%h",
                                 pc, instr, e.pc, e.ins);
                    end
                end
            end
            if (ld_valid === 1'b1) begin
                n_cmp++;
                if (exp_l.size() == 0) begin
                    n_err++;
                    $display("FAIL load_unexpected got ld_data=%h, none expected", ld_data);
                end else begin
                    logic [15:0] el;
                    el = exp_l.pop_front();
                    if (ld_data !== el) begin
                        n_err++;
                        $display("FAIL load got ld_data=%h want %h", ld_data, el);
                    end
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog time limit reached");
        $fatal(1);
    end

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s got=%h want=%h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge ck);
        #1;
    endtask

    task automatic push_f(input logic [8:0] p);
        exp_fetch_t e;
        e.pc  = p;
        e.ins = {7'd0, p};
        exp_f.push_back(e);
    endtask

    // Returns at posedge+1 of the cycle in which pc==t is presented as valid.
    task automatic wait_pc(input logic [8:0] t);
        bit found;
        found = 1'b0;
        for (int k = 0; k < 60 && !found; k++) begin
            step();
            if (instr_valid === 1'b1 && pc === t) found = 1'b1;
        end
        if (!found) begin
            n_cmp++;
            n_err++;
            $display("FAIL wait_pc timeout got pc=%h want pc=%h", pc, t);
        end
    endtask

    initial begin
        rst = 1'b1; start = 1'b0;
        ex_valid = 1'b0; ex_op = 4'b0000; ex_is_jump = 1'b0; ex_next_pc = '0;
        ex_is_write = 1'b0; ex_write_addr = '0; ex_data = '0;
        ld_req = 1'b0; ld_addr = '0;

        repeat (3) @(posedge ck);
        #1;
        mon_en = 1'b1;
        @(negedge ck);
        chk("rst_pc",          16'(pc), 16'h0000);
        chk("rst_instr_valid", 16'(instr_valid), 16'h0000);
        chk("rst_instr",       instr, 16'h0000);
        chk("rst_ld_valid",    16'(ld_valid), 16'h0000);
        chk("rst_ld_data",     ld_data, 16'h0000);
        chk("rst_halted",      16'(halted), 16'h0000);
        chk("rst_fetch_stall", 16'(fetch_stall), 16'h0000);
        chk("rst_mem_we",      16'(mem_we), 16'h0000);

        for (int i = 0; i < 6; i++) push_f(9'(i));

        step(); rst = 1'b0; start = 1'b1;
        step(); start = 1'b0;
        ex_valid = 1'b1; ex_op = 4'b0000;               // NOP: no effect
        step(); ex_valid = 1'b0;

        // Load during fetch: one stall cycle, data next cycle.
        wait_pc(9'd2);
        ld_req = 1'b1; ld_addr = 9'h040; exp_l.push_back(16'hBEEF);
        @(negedge ck);
        chk("ld_fetch_stall", 16'(fetch_stall), 16'h0001);
        chk("ld_mem_addr",    16'(mem_addr), 16'h0040);
        step(); ld_req = 1'b0;
        @(negedge ck);
        chk("ld_stall_release", 16'(fetch_stall), 16'h0000);
        chk("ld_valid_direct",  16'(ld_valid), 16'h0001);

        // Store and load together: store first, then load, fetch stalled twice.
        step();
        ex_valid = 1'b1; ex_is_write = 1'b1; ex_write_addr = 9'h041; ex_data = 16'h1234;
        ld_req = 1'b1; ld_addr = 9'h041;
        @(negedge ck);
        chk("st_mem_we",    16'(mem_we), 16'h0001);
        chk("st_mem_addr",  16'(mem_addr), 16'h0041);
        chk("st_mem_wdata", mem_wdata, 16'h1234);
        chk("st_stall",     16'(fetch_stall), 16'h0001);
        step(); ex_valid = 1'b0; ex_is_write = 1'b0; exp_l.push_back(16'h1234);
        @(negedge ck);
        chk("st_ld_mem_we", 16'(mem_we), 16'h0000);
        chk("st_ld_stall",  16'(fetch_stall), 16'h0001);
        step(); ld_req = 1'b0;
        @(negedge ck);
        chk("st_ld_release", 16'(fetch_stall), 16'h0000);

        // Jump at pc=5 to 0x100: three dead cycles then the target.
        for (int i = 0; i < 3; i++) push_f(9'(9'h100 + i));
        wait_pc(9'd5);
        ex_valid = 1'b1; ex_is_jump = 1'b1; ex_next_pc = 9'h100;
        step(); ex_valid = 1'b0; ex_is_jump = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge ck);
            chk("jmp_flush_iv", 16'(instr_valid), 16'h0000);
            step();
        end
        @(negedge ck);
        chk("jmp_target_iv", 16'(instr_valid), 16'h0001);
        chk("jmp_target_pc", 16'(pc), 16'h0100);

        // Second jump inside FLUSH reloads the window; target near the top to test wrap.
        push_f(9'h1FD); push_f(9'h1FE); push_f(9'h1FF); push_f(9'h000); push_f(9'h001);
        wait_pc(9'h102);
        ex_valid = 1'b1; ex_is_jump = 1'b1; ex_next_pc = 9'h1F0;
        step(); ex_valid = 1'b0; ex_is_jump = 1'b0;
        @(negedge ck);
        chk("jmp2_iv_k1", 16'(instr_valid), 16'h0000);
        step(); ex_valid = 1'b1; ex_is_jump = 1'b1; ex_next_pc = 9'h1FD;
        @(negedge ck);
        chk("jmp2_iv_k2", 16'(instr_valid), 16'h0000);
        step(); ex_valid = 1'b0; ex_is_jump = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge ck);
            chk("jmp2_reload_iv", 16'(instr_valid), 16'h0000);
            step();
        end
        @(negedge ck);
        chk("jmp2_target_iv", 16'(instr_valid), 16'h0001);
        chk("jmp2_target_pc", 16'(pc), 16'h01FD);

        // Halt at pc=1 (after wrap); load served while halted; start resumes at pc=2.
        wait_pc(9'd1);
        ex_valid = 1'b1; ex_op = 4'b1111;
        step(); ex_valid = 1'b0; ex_op = 4'b0000;
        push_f(9'd2); push_f(9'd3);
        @(negedge ck);
        chk("hlt_halted", 16'(halted), 16'h0001);
        chk("hlt_iv",     16'(instr_valid), 16'h0000);
        step(); ld_req = 1'b1; ld_addr = 9'h040; exp_l.push_back(16'hBEEF);
        @(negedge ck);
        chk("hlt_ld_no_stall", 16'(fetch_stall), 16'h0000);
        chk("hlt_ld_mem_addr", 16'(mem_addr), 16'h0040);
        step(); ld_req = 1'b0;
        @(negedge ck);
        chk("hlt_iv_idle", 16'(instr_valid), 16'h0000);
        step(); start = 1'b1;
        @(negedge ck);
        chk("hlt_still_halted", 16'(halted), 16'h0001);
        step(); start = 1'b0;
        @(negedge ck);
        chk("hlt_resumed", 16'(halted), 16'h0000);

        // Reset in the cycle a load is granted: its data never surfaces.
        wait_pc(9'd3);
        ld_req = 1'b1; ld_addr = 9'h040; rst = 1'b1;
        step(); ld_req = 1'b0;
        @(negedge ck);
        chk("rst_mid_ld_valid", 16'(ld_valid), 16'h0000);
        chk("rst_mid_iv",       16'(instr_valid), 16'h0000);
        chk("rst_mid_pc",       16'(pc), 16'h0000);
        chk("rst_mid_halted",   16'(halted), 16'h0000);
        step(); rst = 1'b0;
        @(negedge ck);
        chk("post_rst_ld_valid", 16'(ld_valid), 16'h0000);
        chk("post_rst_stall",    16'(fetch_stall), 16'h0000);
        step();
        @(negedge ck);
        chk("idle_no_fetch_iv", 16'(instr_valid), 16'h0000);
        step();

        chk("fetch_q_left", 16'(exp_f.size()), 16'h0000);
        chk("load_q_left",  16'(exp_l.size()), 16'h0000);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
